// File: rtl/imm_ext_pipe_pkg.sv
// Shared decode constants and default widths for the immediate-extension stage.
// Also holds the parameter legality rule used by the elaboration check.
package imm_ext_pipe_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned IMM_W  = 16;
   localparam int unsigned REG_W  = 5;

   typedef enum logic [1:0] {
      IMM_SIGN   = 2'd0,
      IMM_ZERO   = 2'd1,
      IMM_UPPER  = 2'd2,
      IMM_BRANCH = 2'd3
   } imm_mode_e;

   function automatic bit legal_params(int unsigned in_w, int unsigned out_w,
                                        int unsigned depth);
      return (in_w >= 2) && (in_w + 2 <= out_w) &&
             ((depth == 2) || (depth == 4) || (depth == 8));
   endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for the immediate-extension stage: producer side, consumer side,
// flush and occupancy. The stage itself uses the slave view.
interface imm_ext_pipe_if #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned TAG_W = 5,
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   logic [1:0]       in_mode;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic [CNT_W-1:0] count;

   modport master (
      output flush, in_valid, in_imm, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, count
   );

   modport slave (
      input  flush, in_valid, in_imm, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, count
   );
endinterface

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: sign, zero, upper and branch-offset forms.
module imm_ext_core
   import imm_ext_pipe_pkg::*;
#(
   parameter int unsigned IN_W  = IMM_W,
   parameter int unsigned OUT_W = DATA_W
) (
   input  logic [IN_W-1:0]  imm,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] data
);
   logic [OUT_W-1:0] sext;

   assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

   always_comb begin
      data = sext;
      unique case (imm_mode_e'(mode))
         IMM_SIGN:   data = sext;
         IMM_ZERO:   data = {{(OUT_W-IN_W){1'b0}}, imm};
         IMM_UPPER:  data = {imm, {(OUT_W-IN_W){1'b0}}};
         // Word offset: the sign-extended value times four, top two bits dropped.
         IMM_BRANCH: data = {sext[OUT_W-3:0], 2'b00};
      endcase
   end
endmodule

// File: rtl/imm_ext_pipe.sv
// Registered ID->EX immediate-extension stage: extends at the write edge and buffers
// results with their tags in a small FIFO with valid/ready on both sides and flush.
module imm_ext_pipe
   import imm_ext_pipe_pkg::*;
#(
   parameter int unsigned IN_W  = IMM_W,
   parameter int unsigned OUT_W = DATA_W,
   parameter int unsigned TAG_W = REG_W,
   parameter int unsigned DEPTH = 2
) (
   input logic           clk,
   input logic           rst_n,
   imm_ext_pipe_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   if (!legal_params(IN_W, OUT_W, DEPTH)) begin : g_param_check
      $error("imm_ext_pipe: illegal parameters IN_W=%0d OUT_W=%0d DEPTH=%0d",
             IN_W, OUT_W, DEPTH);
   end

   logic [OUT_W-1:0] ext_data;
   logic [OUT_W-1:0] mem_data [DEPTH];
   logic [TAG_W-1:0] mem_tag  [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push;
   logic             pop;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .imm  (bus.in_imm),
      .mode (bus.in_mode),
      .data (ext_data)
   );

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign bus.in_ready  = (count_q < FULL) || bus.out_ready;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = mem_data[rd_ptr_q];
   assign bus.out_tag   = mem_tag[rd_ptr_q];
   assign bus.count     = count_q;

   assign push = bus.in_valid && bus.in_ready && !bus.flush;
   assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_tag[i]  <= '0;
         end
      end else if (bus.flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_data[wr_ptr_q] <= ext_data;
            mem_tag[wr_ptr_q]  <= bus.in_tag;
            wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed handshake/flush/reset cases on the
// default build, then random traffic on two wider builds against a queue model.
module tb_imm_ext_pipe;

   typedef struct {
      logic [15:0] imm;
      int          mode;
      logic [4:0]  tag;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   imm_ext_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5), .DEPTH(2)) if0 ();
   imm_ext_pipe_if #(.IN_W(12), .OUT_W(32), .TAG_W(5), .DEPTH(4)) if1 ();
   imm_ext_pipe_if #(.IN_W(16), .OUT_W(64), .TAG_W(5), .DEPTH(4)) if2 ();

   imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5), .DEPTH(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0)
   );
   imm_ext_pipe #(.IN_W(12), .OUT_W(32), .TAG_W(5), .DEPTH(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1)
   );
   imm_ext_pipe #(.IN_W(16), .OUT_W(64), .TAG_W(5), .DEPTH(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .bus(if2)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Extension worked out arithmetically: signed value, scaled, reduced modulo 2**out_w.
   function automatic logic [63:0] ref_ext(input logic [15:0] imm, input int mode,
                                           input int in_w, input int out_w);
      longint unsigned raw;
      longint unsigned res;
      longint          sval;
      raw  = 64'(imm) & ((64'd1 << in_w) - 64'd1);
      sval = longint'(raw);
      if (raw >= (64'd1 << (in_w - 1))) sval = sval - longint'(64'd1 << in_w);
      case (mode)
         0:       res = sval;
         1:       res = raw;
         2:       res = raw * (64'd1 << (out_w - in_w));
         default: res = sval * 4;
      endcase
      if (out_w < 64) res = res & ((64'd1 << out_w) - 64'd1);
      return res;
   endfunction

   function automatic ent_t rand_ent();
      ent_t e;
      e.imm  = 16'($urandom);
      e.mode = int'($urandom_range(0, 3));
      e.tag  = 5'($urandom);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive0(input ent_t e);
      if0.in_valid = 1'b1;
      if0.in_imm   = e.imm;
      if0.in_mode  = 2'(e.mode);
      if0.in_tag   = e.tag;
   endtask

   task automatic check_head0(input string tag, input ent_t e);
      check_eq({tag, "_valid"}, 64'(if0.out_valid), 64'd1);
      check_eq({tag, "_data"}, 64'(if0.out_data), ref_ext(e.imm, e.mode, 16, 32));
      check_eq({tag, "_tag"}, 64'(if0.out_tag), 64'(e.tag));
   endtask

   initial begin
      ent_t        q0[$];
      ent_t        q[$];
      ent_t        e;
      ent_t        a;
      ent_t        b;
      logic [31:0] mode_exp [4];
      logic        mready;
      logic        do_push;
      logic        do_pop;

      mode_exp[0] = 32'hFFFF8001;
      mode_exp[1] = 32'h00008001;
      mode_exp[2] = 32'h80010000;
      mode_exp[3] = 32'hFFFE0004;

      {if0.flush, if0.in_valid, if0.in_imm, if0.in_mode, if0.in_tag, if0.out_ready} = '0;
      {if1.flush, if1.in_valid, if1.in_imm, if1.in_mode, if1.in_tag, if1.out_ready} = '0;
      {if2.flush, if2.in_valid, if2.in_imm, if2.in_mode, if2.in_tag, if2.out_ready} = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check_eq("rst_count", 64'(if0.count), 64'd0);
      check_eq("rst_valid", 64'(if0.out_valid), 64'd0);
      check_eq("rst_data", 64'(if0.out_data), 64'd0);
      check_eq("rst_tag", 64'(if0.out_tag), 64'd0);
      check_eq("rst_in_ready", 64'(if0.in_ready), 64'd1);
      check_eq("rst_count1", 64'(if1.count), 64'd0);

      // Each mode on 16'h8001, one cycle latency, streaming with out_ready=1
      tick();
      if0.out_ready = 1'b1;
      for (int m = 0; m < 4; m++) begin
         if0.in_valid = 1'b1;
         if0.in_imm   = 16'h8001;
         if0.in_mode  = 2'(m);
         if0.in_tag   = 5'(m + 3);
         tick();
         check_eq($sformatf("mode%0d_data", m), 64'(if0.out_data), 64'(mode_exp[m]));
         check_eq($sformatf("mode%0d_tag", m), 64'(if0.out_tag), 64'(m + 3));
         check_eq($sformatf("mode%0d_valid", m), 64'(if0.out_valid), 64'd1);
         check_eq($sformatf("mode%0d_count", m), 64'(if0.count), 64'd1);
      end
      if0.in_valid = 1'b0;
      tick();
      check_eq("mode_drain_valid", 64'(if0.out_valid), 64'd0);

      // Backpressure: third input refused while full, head stable, in-order drain
      if0.out_ready = 1'b0;
      a = rand_ent();
      b = rand_ent();
      drive0(a);
      tick();
      drive0(b);
      tick();
      e = rand_ent();
      drive0(e);
      #1;
      check_eq("bp_in_ready", 64'(if0.in_ready), 64'd0);
      check_eq("bp_count", 64'(if0.count), 64'd2);
      tick();
      check_eq("bp_count_hold", 64'(if0.count), 64'd2);
      check_head0("bp_head", a);
      if0.in_valid  = 1'b0;
      if0.out_ready = 1'b1;
      tick();
      check_head0("bp_second", b);
      tick();
      check_eq("bp_empty", 64'(if0.out_valid), 64'd0);
      check_eq("bp_empty_count", 64'(if0.count), 64'd0);

      // Asynchronous reset between edges with two entries buffered
      if0.out_ready = 1'b0;
      drive0(rand_ent());
      tick();
      drive0(rand_ent());
      tick();
      if0.in_valid = 1'b0;
      check_eq("mrst_pre_count", 64'(if0.count), 64'd2);
      #1 rst_n = 1'b0;
      #1;
      check_eq("mrst_valid", 64'(if0.out_valid), 64'd0);
      check_eq("mrst_count", 64'(if0.count), 64'd0);
      check_eq("mrst_in_ready", 64'(if0.in_ready), 64'd1);
      #1 rst_n = 1'b1;

      // Full with simultaneous push and pop, eight entries across pointer wrap
      tick();
      for (int i = 0; i < 2; i++) begin
         e = rand_ent();
         q0.push_back(e);
         drive0(e);
         tick();
      end
      check_eq("pp_full", 64'(if0.count), 64'd2);
      if0.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         e = rand_ent();
         drive0(e);
         #1;
         check_eq($sformatf("pp%0d_in_ready", i), 64'(if0.in_ready), 64'd1);
         tick();
         void'(q0.pop_front());
         q0.push_back(e);
         check_eq($sformatf("pp%0d_count", i), 64'(if0.count), 64'd2);
         check_head0($sformatf("pp%0d", i), q0[0]);
      end
      if0.in_valid = 1'b0;
      tick();
      void'(q0.pop_front());
      check_head0("pp_tail", q0[0]);
      tick();
      void'(q0.pop_front());
      check_eq("pp_done", 64'(if0.out_valid), 64'd0);

      // Flush overrides push and pop
      if0.out_ready = 1'b0;
      drive0(rand_ent());
      tick();
      drive0(rand_ent());
      tick();
      check_eq("fl_pre_count", 64'(if0.count), 64'd2);
      e = rand_ent();
      drive0(e);
      if0.flush     = 1'b1;
      if0.out_ready = 1'b1;
      #1;
      check_eq("fl_in_ready", 64'(if0.in_ready), 64'd1);
      tick();
      if0.flush    = 1'b0;
      if0.in_valid = 1'b0;
      check_eq("fl_count", 64'(if0.count), 64'd0);
      check_eq("fl_valid", 64'(if0.out_valid), 64'd0);
      tick();
      check_eq("fl_no_ghost", 64'(if0.out_valid), 64'd0);

      // Random traffic on the IN_W=12/OUT_W=32 and IN_W=16/OUT_W=64 builds (DEPTH=4)
      for (int cyc = 0; cyc < 400; cyc++) begin
         check_eq("rnd_count1", 64'(if1.count), 64'(q.size()));
         check_eq("rnd_count2", 64'(if2.count), 64'(q.size()));
         check_eq("rnd_valid1", 64'(if1.out_valid), 64'(q.size() != 0));
         check_eq("rnd_valid2", 64'(if2.out_valid), 64'(q.size() != 0));
         if (q.size() != 0) begin
            check_eq("rnd_data1", 64'(if1.out_data), ref_ext(q[0].imm, q[0].mode, 12, 32));
            check_eq("rnd_data2", 64'(if2.out_data), ref_ext(q[0].imm, q[0].mode, 16, 64));
            check_eq("rnd_tag1", 64'(if1.out_tag), 64'(q[0].tag));
            check_eq("rnd_tag2", 64'(if2.out_tag), 64'(q[0].tag));
         end
         e = rand_ent();
         if1.in_valid  = ($urandom_range(0, 3) != 0);
         if1.out_ready = ($urandom_range(0, 2) != 0);
         if1.flush     = ($urandom_range(0, 49) == 0);
         if1.in_imm    = e.imm[11:0];
         if1.in_mode   = 2'(e.mode);
         if1.in_tag    = e.tag;
         if2.in_valid  = if1.in_valid;
         if2.out_ready = if1.out_ready;
         if2.flush     = if1.flush;
         if2.in_imm    = e.imm;
         if2.in_mode   = 2'(e.mode);
         if2.in_tag    = e.tag;
         mready  = (q.size() < 4) || if1.out_ready;
         do_push = if1.in_valid && mready && !if1.flush;
         do_pop  = (q.size() != 0) && if1.out_ready && !if1.flush;
         #1;
         check_eq("rnd_in_ready1", 64'(if1.in_ready), 64'(mready));
         check_eq("rnd_in_ready2", 64'(if2.in_ready), 64'(mready));
         tick();
         if (if1.flush) begin
            q.delete();
         end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
